// File: rtl/brick_pkg.sv
// Shared constants, state/level enums and per-level lookups for the brick state map.
package brick_pkg;

  localparam int ROWS       = 10;
  localparam int COLS       = 30;
  localparam int NUM_BRICKS = ROWS * COLS;
  localparam int IDX_W      = 9;
  localparam int CNT_W      = 9;

  typedef enum logic {
    ST_LOAD,
    ST_READY
  } state_e;

  typedef enum logic [1:0] {
    LVL0 = 2'd0,
    LVL1 = 2'd1,
    LVL2 = 2'd2
  } level_e;

  // Level 3 has no pattern of its own and plays the level 2 layout.
  function automatic level_e level_to_pattern(input logic [1:0] lvl);
    case (lvl)
      2'd0:    return LVL0;
      2'd1:    return LVL1;
      default: return LVL2;
    endcase
  endfunction

  // The special brick always sits in column 15 of a row that depends on the level.
  function automatic logic [IDX_W-1:0] special_index(input level_e lvl);
    case (lvl)
      LVL0:    return 9'd135;
      LVL1:    return 9'd165;
      default: return 9'd285;
    endcase
  endfunction

endpackage

// File: rtl/brick_row_pattern.sv
// Combinational lookup of one row of a level's brick layout and its popcount.
module brick_row_pattern
  import brick_pkg::*;
(
  input  logic [1:0]      i_level,
  input  logic [3:0]      i_row,
  output logic [COLS-1:0] o_pattern,
  output logic [4:0]      o_count
);

  level_e w_level;

  assign w_level = level_e'(i_level);

  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    o_pattern = '0;
    o_count   = '0;
    if (int'(i_row) < ROWS) begin
      for (int c = 0; c < COLS; c++) begin
        case (w_level)
          LVL0:    o_pattern[c] = (i_row < 4'd5);
          LVL1:    o_pattern[c] = (((int'(i_row) + c) % 2) == 0);
          default: o_pattern[c] = 1'b1;
        endcase
      end
    end
    for (int c = 0; c < COLS; c++) begin
      o_count = o_count + {4'b0, o_pattern[c]};
    end
  end

endmodule

// File: rtl/brick_state_map.sv
// Alive/dead map of the breakout bricks: per-level load, hit handshake, remaining count.
// Optional BRICK_MULTIHIT_EN makes row-0 bricks take two hits (first one cracks).
module brick_state_map #(
  parameter int ROWS = brick_pkg::ROWS,
  parameter int COLS = brick_pkg::COLS
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic [1:0]           iLevel,
  input  logic                 iLoad,
  input  logic                 iHit_valid,
  input  logic [3:0]           iHit_row,
  input  logic [4:0]           iHit_col,
  output logic                 oHit_ack,
  output logic                 oHit_result,
  output logic [ROWS*COLS-1:0] oState_flag,
  output logic [COLS-1:0]      oCracked,
  output logic                 oSpecial_attacked,
  output logic [8:0]           oRemaining,
  output logic                 oReady,
  output logic                 oCleared
);

  import brick_pkg::*;

  state_e                 r_state;
  state_e                 w_next_state;
  level_e                 r_level;
  logic [3:0]             r_row_ptr;
  logic [ROWS*COLS-1:0]   r_flags;
  logic [CNT_W-1:0]       r_remaining;
  logic                   r_hit_ack;
  logic                   r_hit_result;
  logic                   r_special;

  logic [COLS-1:0]        w_row_pat;
  logic [4:0]             w_row_cnt;
  logic                   w_last_row;
  logic                   w_in_range;
  logic [IDX_W-1:0]       w_idx;
  logic                   w_alive;
  logic                   w_serve;
  logic                   w_crack;

  brick_row_pattern u_row_pattern (
    .i_level   (r_level),
    .i_row     (r_row_ptr),
    .o_pattern (w_row_pat),
    .o_count   (w_row_cnt)
  );

  assign w_last_row = (int'(r_row_ptr) == ROWS - 1);
  assign w_in_range = (int'(iHit_row) < ROWS) && (int'(iHit_col) < COLS);
  assign w_idx      = 9'(iHit_row) * 9'(COLS) + 9'(iHit_col);
  assign w_alive    = w_in_range && r_flags[w_idx];

  // The cycle right after an ack is blocked so a requester still holding valid is not served twice.
  assign w_serve = (r_state == ST_READY) && iHit_valid && !iLoad && !r_hit_ack;

`ifdef BRICK_MULTIHIT_EN
  logic [COLS-1:0] r_cracked;

  assign w_crack  = (iHit_row == 4'd0) && !r_cracked[iHit_col];
  assign oCracked = r_cracked;
`else
  assign w_crack  = 1'b0;
  assign oCracked = '0;
`endif

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_state <= ST_LOAD;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (iLoad) begin
      w_next_state = ST_LOAD;
    end else if ((r_state == ST_LOAD) && w_last_row) begin
      w_next_state = ST_READY;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      // NOTE: the brick vector is plain flops (not RAM), so it is cleared on reset like any register.
      r_flags      <= '0;
      r_level      <= LVL0;
      r_row_ptr    <= '0;
      r_remaining  <= '0;
      r_hit_ack    <= 1'b0;
      r_hit_result <= 1'b0;
      r_special    <= 1'b0;
`ifdef BRICK_MULTIHIT_EN
      r_cracked    <= '0;
`endif
    end else begin
      r_hit_ack    <= 1'b0;
      r_hit_result <= 1'b0;
      r_special    <= 1'b0;
      if (iLoad) begin
        r_level     <= level_to_pattern(iLevel);
        r_row_ptr   <= '0;
        r_remaining <= '0;
`ifdef BRICK_MULTIHIT_EN
        r_cracked   <= '0;
`endif
      end else if (r_state == ST_LOAD) begin
        r_flags[int'(r_row_ptr)*COLS +: COLS] <= w_row_pat;
        r_remaining <= r_remaining + {4'b0, w_row_cnt};
        r_row_ptr   <= w_last_row ? 4'd0 : r_row_ptr + 4'd1;
      end else if (w_serve) begin
        r_hit_ack <= 1'b1;
        if (w_alive) begin
          r_hit_result <= 1'b1;
          if (w_crack) begin
`ifdef BRICK_MULTIHIT_EN
            r_cracked[iHit_col] <= 1'b1;
`endif
          end else begin
            r_flags[w_idx] <= 1'b0;
            if (r_remaining != '0) begin
              r_remaining <= r_remaining - 9'd1;
            end
            r_special <= (w_idx == special_index(r_level));
          end
        end
      end
    end
  end

  assign oState_flag       = r_flags;
  assign oRemaining        = r_remaining;
  assign oHit_ack          = r_hit_ack;
  assign oHit_result       = r_hit_result;
  assign oSpecial_attacked = r_special;
  assign oReady            = (r_state == ST_READY);
  assign oCleared          = oReady && (r_remaining == '0);

endmodule

// File: tb/tb_brick_state_map.sv
// Self-checking bench for brick_state_map: directed steps plus random hits against a brick-array model.
module tb_brick_state_map;

  logic         iCLK = 1'b0;
  logic         iRST;
  logic [1:0]   iLevel;
  logic         iLoad;
  logic         iHit_valid;
  logic [3:0]   iHit_row;
  logic [4:0]   iHit_col;
  logic         oHit_ack;
  logic         oHit_result;
  logic [299:0] oState_flag;
  logic [29:0]  oCracked;
  logic         oSpecial_attacked;
  logic [8:0]   oRemaining;
  logic         oReady;
  logic         oCleared;

  int n_checks = 0;
  int n_errors = 0;

  // Model: one bit per brick, addressed as [row][col].
  bit m_alive [10][30];
  bit m_cracked [30];
  int m_rem;
  int m_lvl;

  always #5 iCLK = ~iCLK;

  brick_state_map dut (
    .iCLK              (iCLK),
    .iRST              (iRST),
    .iLevel            (iLevel),
    .iLoad             (iLoad),
    .iHit_valid        (iHit_valid),
    .iHit_row          (iHit_row),
    .iHit_col          (iHit_col),
    .oHit_ack          (oHit_ack),
    .oHit_result       (oHit_result),
    .oState_flag       (oState_flag),
    .oCracked          (oCracked),
    .oSpecial_attacked (oSpecial_attacked),
    .oRemaining        (oRemaining),
    .oReady            (oReady),
    .oCleared          (oCleared)
  );

  task automatic check(input string tag, input logic [299:0] obs, input logic [299:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit pattern_bit(input int lvl, input int r, input int c);
    if (lvl == 0) return r < 5;
    if (lvl == 1) return ((r + c) % 2) == 0;
    return 1'b1;
  endfunction

  function automatic int special_of(input int lvl);
    if (lvl == 0) return 4 * 30 + 15;
    if (lvl == 1) return 5 * 30 + 15;
    return 9 * 30 + 15;
  endfunction

  function automatic logic [299:0] model_flags();
    logic [299:0] v = '0;
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 30; c++)
        v[r*30 + c] = m_alive[r][c];
    return v;
  endfunction

  function automatic logic [29:0] model_cracked();
    logic [29:0] v = '0;
    for (int c = 0; c < 30; c++) v[c] = m_cracked[c];
    return v;
  endfunction

  task automatic model_load(input int lvl_in);
    m_lvl = (lvl_in == 3) ? 2 : lvl_in;
    m_rem = 0;
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 30; c++) begin
        m_alive[r][c] = pattern_bit(m_lvl, r, c);
        if (m_alive[r][c]) m_rem++;
      end
    for (int c = 0; c < 30; c++) m_cracked[c] = 1'b0;
  endtask

  task automatic model_hit(input int r, input int c, output bit res, output bit sp);
    res = 1'b0;
    sp  = 1'b0;
    if (r < 10 && c < 30 && m_alive[r][c]) begin
      res = 1'b1;
`ifdef BRICK_MULTIHIT_EN
      if (r == 0 && !m_cracked[c]) begin
        m_cracked[c] = 1'b1;
        return;
      end
`endif
      m_alive[r][c] = 1'b0;
      m_rem--;
      sp = (r * 30 + c) == special_of(m_lvl);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_flags"}, oState_flag, model_flags());
    check({tag, "_remaining"}, 300'(oRemaining), 300'(m_rem));
    check({tag, "_cracked"}, 300'(oCracked), 300'(model_cracked()));
    check({tag, "_cleared"}, 300'(oCleared), 300'(m_rem == 0));
  endtask

  // Expects the load to have been sampled at the previous edge (or reset just released).
  task automatic wait_load(input string tag);
    repeat (9) @(posedge iCLK);
    #1 check({tag, "_ready_early"}, 300'(oReady), 300'(0));
    @(posedge iCLK);
    #1 check({tag, "_ready"}, 300'(oReady), 300'(1));
  endtask

  task automatic do_load(input int lvl);
    iLevel = 2'(lvl);
    iLoad  = 1'b1;
    @(posedge iCLK);
    #1 iLoad = 1'b0;
    model_load(lvl);
    wait_load("load");
    check_all("load");
  endtask

  task automatic do_hit(input int r, input int c);
    int waited = 0;
    bit got = 1'b0;
    bit res, sp;
    logic [31:0] rv = 32'(r);
    logic [31:0] cv = 32'(c);
    iHit_row   = rv[3:0];
    iHit_col   = cv[4:0];
    iHit_valid = 1'b1;
    while (!got && waited < 40) begin
      @(posedge iCLK);
      #1 waited++;
      got = oHit_ack;
    end
    model_hit(r, c, res, sp);
    check("hit_latency", 300'(waited), 300'(1));
    check("hit_result", 300'(oHit_result), 300'(res));
    check("hit_special", 300'(oSpecial_attacked), 300'(sp));
    check_all("hit");
    iHit_valid = 1'b0;
    @(posedge iCLK);
    #1 check("ack_pulse", 300'(oHit_ack), 300'(0));
    check("special_pulse", 300'(oSpecial_attacked), 300'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit res, sp;
    iRST = 1'b0; iLevel = 2'd0; iLoad = 1'b0;
    iHit_valid = 1'b0; iHit_row = '0; iHit_col = '0;

    // Reset state, then automatic level 0 load.
    repeat (3) @(posedge iCLK);
    #1 check("rst_flags", oState_flag, '0);
    check("rst_remaining", 300'(oRemaining), 300'(0));
    check("rst_ready", 300'(oReady), 300'(0));
    check("rst_ack", 300'(oHit_ack), 300'(0));
    iRST = 1'b1;
    model_load(0);
    wait_load("boot");
    check_all("boot");
    check("boot_lo_ones", 300'(oState_flag[149:0]), {150'b0, {150{1'b1}}});
    check("boot_hi_zero", 300'(oState_flag[299:150]), '0);

    // Directed hits on level 0: alive, repeat (dead), special, out of range.
    do_hit(2, 3);
    check("r2c3_flag", 300'(oState_flag[63]), 300'(0));
    check("r2c3_count", 300'(oRemaining), 300'(149));
    do_hit(2, 3);
    check("r2c3_again_count", 300'(oRemaining), 300'(149));
    do_hit(4, 15);
    check("special_flag", 300'(oState_flag[135]), 300'(0));
    do_hit(11, 0);
    do_hit(3, 31);

    // Valid held across an ack: second service no earlier than two cycles later.
    iHit_row = 4'd1; iHit_col = 5'd9; iHit_valid = 1'b1;
    @(posedge iCLK);
    #1 model_hit(1, 9, res, sp);
    check("hold_ack1", 300'(oHit_ack), 300'(1));
    check("hold_res1", 300'(oHit_result), 300'(res));
    @(posedge iCLK);
    #1 check("hold_gap", 300'(oHit_ack), 300'(0));
    @(posedge iCLK);
    #1 model_hit(1, 9, res, sp);
    check("hold_ack2", 300'(oHit_ack), 300'(1));
    check("hold_res2", 300'(oHit_result), 300'(res));
    iHit_valid = 1'b0;
    @(posedge iCLK);
    #1 check_all("hold");

    // Random hits on level 0.
    for (int i = 0; i < 40; i++) do_hit(int'($urandom_range(11, 0)), int'($urandom_range(31, 0)));

    // Level 1: clear every brick one by one.
    do_load(1);
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 30; c++)
        for (int k = 0; k < 3 && m_alive[r][c]; k++) do_hit(r, c);
    check("l1_empty", 300'(oRemaining), 300'(0));
    check("l1_cleared", 300'(oCleared), 300'(1));
    do_hit(5, 15);

    // Level 2 reload, then the two-hit behaviour of row 0.
    do_load(2);
    check("l2_all", oState_flag, {300{1'b1}});
    do_hit(0, 7);
`ifdef BRICK_MULTIHIT_EN
    check("mh_cracked", 300'(oCracked[7]), 300'(1));
    check("mh_flag_kept", 300'(oState_flag[7]), 300'(1));
    check("mh_count_kept", 300'(oRemaining), 300'(300));
    do_hit(0, 7);
`endif
    check("r0c7_flag", 300'(oState_flag[7]), 300'(0));
    check("r0c7_count", 300'(oRemaining), 300'(299));
    for (int i = 0; i < 40; i++) do_hit(int'($urandom_range(15, 0)), int'($urandom_range(31, 0)));

    // Hit held while a load pulses in READY: no ack during the load, served right after.
    iHit_row = 4'd3; iHit_col = 5'd3; iHit_valid = 1'b1;
    iLevel = 2'd0; iLoad = 1'b1;
    @(posedge iCLK);
    #1 iLoad = 1'b0;
    model_load(0);
    for (int k = 0; k < 10; k++) begin
      check("pend_no_ack", 300'(oHit_ack), 300'(0));
      @(posedge iCLK);
      #1;
    end
    check("pend_ready", 300'(oReady), 300'(1));
    check("pend_no_ack_last", 300'(oHit_ack), 300'(0));
    @(posedge iCLK);
    #1 model_hit(3, 3, res, sp);
    check("pend_ack", 300'(oHit_ack), 300'(1));
    check("pend_result", 300'(oHit_result), 300'(res));
    iHit_valid = 1'b0;
    @(posedge iCLK);
    #1 check_all("pend");

    // Load restarted mid-load; level 3 plays as level 2.
    iLevel = 2'd1; iLoad = 1'b1;
    @(posedge iCLK);
    #1 iLoad = 1'b0;
    repeat (4) @(posedge iCLK);
    #1 iLevel = 2'd3; iLoad = 1'b1;
    @(posedge iCLK);
    #1 iLoad = 1'b0;
    model_load(3);
    wait_load("restart");
    check_all("restart");
    do_hit(9, 15);

    // Reset in the middle of a load returns outputs to reset values at once.
    iLevel = 2'd1; iLoad = 1'b1;
    @(posedge iCLK);
    #1 iLoad = 1'b0;
    repeat (3) @(posedge iCLK);
    #2 iRST = 1'b0;
    #1 check("midrst_flags", oState_flag, '0);
    check("midrst_remaining", 300'(oRemaining), 300'(0));
    check("midrst_ready", 300'(oReady), 300'(0));
    @(posedge iCLK);
    #1 iRST = 1'b1;
    model_load(0);
    wait_load("reboot");
    check_all("reboot");
    for (int i = 0; i < 20; i++) do_hit(int'($urandom_range(11, 0)), int'($urandom_range(31, 0)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
